// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory access unit:
// DMType encodings, FSM states, byte-enable and load-extend functions.
package dm_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  function automatic logic [3:0] be_of(input logic [2:0] t, input logic [1:0] a);
    case (t)
      DM_WORD:           return 4'b1111;
      DM_HALF, DM_HALFU: return a[1] ? 4'b1100 : 4'b0011;
      DM_BYTE, DM_BYTEU: return 4'b0001 << a;
      default:           return 4'b0000;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend per access type.
  function automatic logic [31:0] load_ext(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (t)
      DM_HALF:  return {{16{sh[15]}}, sh[15:0]};
      DM_HALFU: return {16'h0000, sh[15:0]};
      DM_BYTE:  return {{24{sh[7]}}, sh[7:0]};
      DM_BYTEU: return {24'h000000, sh[7:0]};
      default:  return d;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic: byte enables, store replication, load
// extraction/extension and alignment check for one access.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  dmtype,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  always_comb begin
    be        = be_of(dmtype, addr);
    rdata_ext = load_ext(dmtype, addr, mem_rdata);
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (dmtype)
      DM_WORD: misalign = (addr != 2'b00);
      DM_HALF, DM_HALFU: begin
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr[0];
      end
      DM_BYTE, DM_BYTEU: wdata_rep = {4{wdata[7:0]}};
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access FSM: turns CPU load/store requests into req/ack word-bus
// transactions, with alignment, illegal-type and timeout error reporting.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    dmtype,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  logic          we_q;
  logic [2:0]    dmtype_q;
  logic [1:0]    addr_lo_q;
  logic [31:0]   load_q;
  logic [CW-1:0] cnt;

  logic [2:0]    al_type;
  logic [1:0]    al_addr;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_rdata;
  logic          al_misalign;
  logic          illegal;

  // In IDLE the lane logic looks at the live request; afterwards at the
  // latched access so load extension uses the captured type/offset.
  always_comb begin
    al_type = dmtype_q;
    al_addr = addr_lo_q;
    if (state == IDLE) begin
      al_type = dmtype;
      al_addr = addr[1:0];
    end
  end

  assign illegal = (dmtype > DM_BYTEU);

  dm_lane_align u_align (
    .dmtype    (al_type),
    .addr      (al_addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      dmtype_q  <= '0;
      addr_lo_q <= '0;
      load_q    <= '0;
      cnt       <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q      <= we;
            dmtype_q  <= dmtype;
            addr_lo_q <= addr[1:0];
            busy      <= 1'b1;
            if (illegal || al_misalign) begin
              state <= ERR;
            end else begin
              state     <= BUS;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= addr[AW-1:2];
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
              cnt       <= '0;
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            if (!we_q) load_q <= al_rdata;
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
            state   <= ERR;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!we_q) rdata <= load_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          done  <= 1'b1;
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: expected completions are queued when a
// request is driven and compared when done pulses.
module tb_dm_access_ctrl;

  logic        clk;
  logic        rstn;
  logic        req;
  logic        we;
  logic [2:0]  dmtype;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  dm_access_ctrl #(.TIMEOUT(16), .AW(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .we        (we),
    .dmtype    (dmtype),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge with it idle.
  task automatic do_access(input string tag, input logic w, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int ack_at,
                           input logic exp_bus, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic exp_err,
                           input logic [31:0] exp_rd, input int exp_lat,
                           input int exp_req_cycles);
    exp_t e;
    int   k;
    int   nreq;
    e.err   = exp_err;
    e.rdata = exp_rd;
    sb.push_back(e);
    req = 1'b1; we = w; dmtype = t; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    k = 0;
    nreq = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (exp_bus) begin
      chk({tag, "_addr"}, {2'b00, mem_addr}, {2'b00, a[31:2]});
      chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
      chk({tag, "_we"}, 32'(mem_we), 32'(w));
      if (w) chk({tag, "_wdata"}, mem_wdata, exp_wd);
    end
    while (!done && k < 64) begin
      if (mem_req) nreq++;
      if (k == ack_at) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
      @(negedge clk);
      k++;
    end
    mem_ack = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    chk({tag, "_req_cycles"}, 32'(nreq), 32'(exp_req_cycles));
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(e.err));
    chk({tag, "_rdata"}, rdata, e.rdata);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'd0, done, err}, 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstn = 1'b0; req = 1'b0; we = 1'b0; dmtype = 3'd0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {27'd0, done, err, busy, mem_req, mem_we}, 32'd0);
    chk("rst_bus", {2'b00, mem_addr} | 32'(mem_be) | mem_wdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    //        tag        we  type    addr          wdata          mem_rdata     ack  bus  be       wdata          err  rdata          lat req
    do_access("ld_word",  0, 3'b000, 32'h00000100, 32'h0,         32'hDEADBEEF, 0,   1, 4'b1111, 32'h0,         0, 32'hDEADBEEF, 2,  1);
    do_access("ld_byte",  0, 3'b011, 32'h00000103, 32'h0,         32'h80123456, 0,   1, 4'b1000, 32'h0,         0, 32'hFFFFFF80, 2,  1);
    do_access("ld_byteu", 0, 3'b100, 32'h00000103, 32'h0,         32'h80123456, 0,   1, 4'b1000, 32'h0,         0, 32'h00000080, 2,  1);
    do_access("st_half",  1, 3'b001, 32'h00000202, 32'h1234ABCD, 32'h0,         0,   1, 4'b1100, 32'hABCDABCD, 0, 32'h00000080, 2,  1);
    do_access("st_mis",   1, 3'b001, 32'h00000201, 32'h1234ABCD, 32'h0,         0,   0, 4'b0000, 32'h0,         1, 32'h00000080, 1,  0);
    do_access("ld_hwait", 0, 3'b001, 32'h00000106, 32'h0,         32'h87654321, 3,   1, 4'b1100, 32'h0,         0, 32'hFFFF8765, 5,  4);
    do_access("ld_halfu", 0, 3'b010, 32'h00000104, 32'h0,         32'h1234F00D, 1,   1, 4'b0011, 32'h0,         0, 32'h0000F00D, 3,  2);
    do_access("ld_tmo",   0, 3'b000, 32'h00000300, 32'h0,         32'h0,        -1,  1, 4'b1111, 32'h0,         1, 32'h0000F00D, 17, 16);
    do_access("illegal",  0, 3'b111, 32'h00000000, 32'h0,         32'h0,        0,   0, 4'b0000, 32'h0,         1, 32'h0000F00D, 1,  0);
    do_access("st_byte",  1, 3'b011, 32'h00000001, 32'h000000AB, 32'h0,         0,   1, 4'b0010, 32'hABABABAB, 0, 32'h0000F00D, 2,  1);
    do_access("ld_wmis",  0, 3'b000, 32'h00000102, 32'h0,         32'h0,        0,   0, 4'b0000, 32'h0,         1, 32'h0000F00D, 1,  0);

    // Abort a load in BUS with an asynchronous reset between clock edges.
    req = 1'b1; we = 1'b0; dmtype = 3'b000; addr = 32'h00000400;
    @(negedge clk);
    req = 1'b0;
    chk("rstbus_req_on", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rstbus_async", {30'd0, mem_req, busy}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstbus_no_done", 32'(done), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    do_access("post_rst", 0, 3'b000, 32'h00000010, 32'h0,         32'h01020304, 0,   1, 4'b1111, 32'h0,         0, 32'h01020304, 2,  1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequential data-memory access unit that consumes the decoder's MemWrite and DMType controls and turns them into word-bus transactions.
- Sits between the ALU result / rs2 datapath and a 32-bit word-addressed data memory with a req/ack handshake.
- Builds store byte-lanes and enables, and extracts and extends load data per DMType.
- Flags misaligned accesses, illegal DMType codes and bus timeouts.

Parameters:
- TIMEOUT, 16: cycles in BUS without mem_ack before an error is raised; 0 disables the timeout.
- AW, 32: CPU byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  1  CPU access request; sampled only in IDLE.
- we  in  1  1 = store (MemWrite), 0 = load.
- dmtype  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- addr  in  AW  byte address.
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load result; valid while done=1 and held until the next done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on a failed access.
- busy  out  1  high whenever state != IDLE; the pipeline stalls on it.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  AW-2  word address, equal to addr[AW-1:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  bus read data; valid with mem_ack.
- mem_ack  in  1  bus acknowledge.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values: state IDLE; rdata, done, err, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata all 0.
- Registered outputs: every output is driven from a flop. A reset assertion mid-operation drops mem_req immediately and aborts the access with no done.

- IDLE:
  - When req=1, latch we, dmtype, addr and wdata.
  - If dmtype is 101–111, or a half access has addr[0]=1, or a word access has addr[1:0]!=0, go to ERR.
  - Otherwise go to BUS.
- BUS:
  - Drive mem_req=1, mem_we=we, mem_addr from the latched address.
  - mem_be: word 1111; half 0011 (addr[1]=0) or 1100 (addr[1]=1); byte 0001 << addr[1:0]. Loads drive the same enables.
  - mem_wdata: word = wdata; half = {2{wdata[15:0]}}; byte = {4{wdata[7:0]}}.
  - Timeout counter counts cycles spent in BUS.
  - On mem_ack=1: if load, select the lane by addr[1:0], then sign-extend (000/001/011) or zero-extend (010/100) into rdata; go to DONE.
  - If the counter reaches TIMEOUT-1 with no ack and TIMEOUT != 0, go to ERR.
  - Exit from BUS in either case clears mem_req.
- DONE: done=1 for one cycle, err=0, then return to IDLE.
- ERR: done=1 and err=1 for one cycle, rdata unchanged, no bus transaction issued (or the bus transaction abandoned), then return to IDLE.

- Latency: with a zero-wait memory (ack in the first BUS cycle), done is asserted two clocks after the req-sampling edge. Each wait cycle adds one clock. A back-to-back req is accepted on the cycle after done.
- Ignored inputs: req outside IDLE; mem_ack outside BUS.
- Store results: rdata does not change on a store.
- Counter width: $clog2(TIMEOUT+1). The counter clears on entry to BUS.

Decomposition:
- Package dm_pkg:
  - DMType constants DM_WORD/DM_HALF/DM_HALFU/DM_BYTE/DM_BYTEU.
  - State enum IDLE/BUS/DONE/ERR.
  - Byte-enable and load-extend functions.
- One combinational sub-module, dm_lane_align: (dmtype, addr[1:0], wdata, mem_rdata) -> (be, wdata_rep, rdata_ext, misalign). The FSM instantiates it.

Test Plan:
- Word load: dmtype=000, addr=0x100, mem_rdata=0xDEADBEEF, ack in first BUS cycle -> mem_addr=0x40, mem_be=1111, done two clocks after req, rdata=0xDEADBEEF.
- Signed byte load: dmtype=011, addr=0x103, mem_rdata=0x80123456 -> mem_be=1000, rdata=0xFFFFFF80. Repeat with dmtype=100 -> rdata=0x00000080.
- Half store: dmtype=001, we=1, addr=0x202, wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, done with err=0. Misaligned variant addr=0x201 -> err=1, done=1, mem_req never asserted.
- Wait states and timeout: ack after 3 wait cycles -> done at clock 5. With TIMEOUT=16 and no ack -> err pulse at the 16th BUS cycle, mem_req deasserted. Illegal dmtype=111 -> immediate err.
- Reset mid-BUS: rstn low during BUS -> mem_req=0 and busy=0 asynchronously, no done. After release, a new req completes normally.
